wb_retire_stage: RTL and testbench

//   Parametrised writeback/retire stage for the Y86-64 pipeline. Holds the W pipeline register,

---
 rtl/y86_pkg.sv | 31 +++
 rtl/y86_regfile.sv | 48 ++++
 rtl/wb_retire_stage.sv | 132 +++++++++++++
 tb/tb_wb_retire_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the writeback/retire slice: status codes,
// icodes, the "no register" id and the processor status state encoding.
package y86_pkg;

   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   localparam logic [3:0] IHALT = 4'h0;
   localparam logic [3:0] INOP  = 4'h1;
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_HALT = 2'd1,
      ST_ERR  = 2'd2
   } cpu_state_e;

   // A register id names a real register only if it is not RNONE and in range.
   function automatic logic reg_ok(input logic [3:0] id, input int num_regs);
      return (id != RNONE) && (int'(id) < num_regs);
   endfunction

   // Status reported once the pipeline has faulted; unknown codes are treated as SINS.
   function automatic logic [2:0] fault_stat(input logic [2:0] stat);
      return (stat == SADR) ? SADR : SINS;
   endfunction

endpackage

// File: rtl/y86_regfile.sv
// Architectural register file: two write ports (M wins over E on the same id)
// and RD_PORTS combinational read ports that see this cycle's writes.
module y86_regfile
   import y86_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 15,
   parameter int RD_PORTS = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       we_e_i,
   input  logic [3:0]                 waddr_e_i,
   input  logic [DATA_W-1:0]          wdata_e_i,
   input  logic                       we_m_i,
   input  logic [3:0]                 waddr_m_i,
   input  logic [DATA_W-1:0]          wdata_m_i,
   input  logic [RD_PORTS*4-1:0]      rd_addr_i,
   output logic [RD_PORTS*DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Write storage; the M write is applied last so it overrides E on a shared id.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (we_e_i) regs[waddr_e_i] <= wdata_e_i;
         if (we_m_i) regs[waddr_m_i] <= wdata_m_i;
      end
   end

   // Read ports with write-through bypass, valM checked before valE.
   always_comb begin
      rd_data_o = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         logic [3:0] a;
         a = rd_addr_i[p*4 +: 4];
         if (reg_ok(a, NUM_REGS)) begin
            if (we_m_i && (a == waddr_m_i))      rd_data_o[p*DATA_W +: DATA_W] = wdata_m_i;
            else if (we_e_i && (a == waddr_e_i)) rd_data_o[p*DATA_W +: DATA_W] = wdata_e_i;
            else                                 rd_data_o[p*DATA_W +: DATA_W] = regs[a];
         end
      end
   end

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: W pipeline register, retire decision, sticky
// RUN/HALT/ERR status tracking and a saturating retired-instruction counter.
// State is visible on dbg_state_o for checkers.
module wb_retire_stage
   import y86_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int NUM_REGS = 15,
   parameter int RD_PORTS = 2,
   parameter int CNT_W    = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       stall_i,
   input  logic                       bubble_i,
   input  logic [2:0]                 m_stat_i,
   input  logic [3:0]                 m_icode_i,
   input  logic [DATA_W-1:0]          m_valE_i,
   input  logic [DATA_W-1:0]          m_valM_i,
   input  logic [3:0]                 m_dstE_i,
   input  logic [3:0]                 m_dstM_i,
   input  logic [RD_PORTS*4-1:0]      rd_addr_i,
   output logic [RD_PORTS*DATA_W-1:0] rd_data_o,
   output logic [2:0]                 W_stat_o,
   output logic [3:0]                 W_icode_o,
   output logic [DATA_W-1:0]          W_valE_o,
   output logic [DATA_W-1:0]          W_valM_o,
   output logic [3:0]                 W_dstE_o,
   output logic [3:0]                 W_dstM_o,
   output logic [2:0]                 cpu_stat_o,
   output logic                       halted_o,
   output logic [CNT_W-1:0]           retired_cnt_o,
   output cpu_state_e                 dbg_state_o
);

   logic       w_new;
   logic       commit;
   logic       halt_retire;
   cpu_state_e state_q, state_nxt;
   logic [2:0] stat_q, stat_nxt;

   // W register: reset/bubble insert a nop, stall holds, otherwise capture M.
   // w_new marks the first cycle of a freshly loaded real instruction only.
   always_ff @(posedge clk_i) begin
      if (rst_i || bubble_i) begin
         W_stat_o  <= SBUB;
         W_icode_o <= INOP;
         W_valE_o  <= '0;
         W_valM_o  <= '0;
         W_dstE_o  <= RNONE;
         W_dstM_o  <= RNONE;
         w_new     <= 1'b0;
      end else if (stall_i) begin
         w_new     <= 1'b0;
      end else begin
         W_stat_o  <= m_stat_i;
         W_icode_o <= m_icode_i;
         W_valE_o  <= m_valE_i;
         W_valM_o  <= m_valM_i;
         W_dstE_o  <= m_dstE_i;
         W_dstM_o  <= m_dstM_i;
         w_new     <= (m_stat_i != SBUB);
      end
   end

   assign commit      = w_new && (W_stat_o == SAOK) && (state_q == ST_RUN);
   assign halt_retire = w_new && (W_stat_o == SHLT) && (state_q == ST_RUN);

   y86_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .RD_PORTS (RD_PORTS)
   ) u_regfile (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_e_i    (commit && reg_ok(W_dstE_o, NUM_REGS)),
      .waddr_e_i (W_dstE_o),
      .wdata_e_i (W_valE_o),
      .we_m_i    (commit && reg_ok(W_dstM_o, NUM_REGS)),
      .waddr_m_i (W_dstM_o),
      .wdata_m_i (W_valM_o),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o)
   );

   // Status state register and the status code reported alongside it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         stat_q  <= SAOK;
      end else begin
         state_q <= state_nxt;
         stat_q  <= stat_nxt;
      end
   end

   // Next state: only a new instruction in RUN can move the machine; HALT/ERR are sticky.
   always_comb begin
      state_nxt = state_q;
      stat_nxt  = stat_q;
      if ((state_q == ST_RUN) && w_new) begin
         case (W_stat_o)
            SAOK, SBUB: begin
               state_nxt = ST_RUN;
               stat_nxt  = SAOK;
            end
            SHLT: begin
               state_nxt = ST_HALT;
               stat_nxt  = SHLT;
            end
            default: begin
               state_nxt = ST_ERR;
               stat_nxt  = fault_stat(W_stat_o);
            end
         endcase
      end
   end

   // Retired count: normal commits plus the halt itself, saturating at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         retired_cnt_o <= '0;
      end else if ((commit || halt_retire) && (retired_cnt_o != '1)) begin
         retired_cnt_o <= retired_cnt_o + 1'b1;
      end
   end

   assign cpu_stat_o  = stat_q;
   assign halted_o    = (state_q != ST_RUN);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage. Drivers push expected values with a selector
// naming the observed output; the negedge monitor pops and compares.
// A second instance with CNT_W=4 shares the same stimulus for saturation.
module tb_wb_retire_stage;
   import y86_pkg::*;

   localparam int DATA_W = 64;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, stall, bubble;
   logic [2:0]        m_stat;
   logic [3:0]        m_icode, m_dstE, m_dstM;
   logic [DATA_W-1:0] m_valE, m_valM;
   logic [7:0]        rd_addr;

   logic [127:0]      rd_data, s_rd_data;
   logic [2:0]        w_stat, s_w_stat, cpu_stat, s_cpu_stat;
   logic [3:0]        w_icode, s_w_icode, w_dstE, s_w_dstE, w_dstM, s_w_dstM;
   logic [DATA_W-1:0] w_valE, s_w_valE, w_valM, s_w_valM;
   logic              halted, s_halted;
   logic [31:0]       cnt;
   logic [3:0]        s_cnt;
   cpu_state_e        dbg_state, s_dbg_state;

   wb_retire_stage #(.CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
      .m_stat_i(m_stat), .m_icode_i(m_icode), .m_valE_i(m_valE), .m_valM_i(m_valM),
      .m_dstE_i(m_dstE), .m_dstM_i(m_dstM), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .W_stat_o(w_stat), .W_icode_o(w_icode), .W_valE_o(w_valE), .W_valM_o(w_valM),
      .W_dstE_o(w_dstE), .W_dstM_o(w_dstM), .cpu_stat_o(cpu_stat), .halted_o(halted),
      .retired_cnt_o(cnt), .dbg_state_o(dbg_state)
   );

   wb_retire_stage #(.CNT_W(4)) dut_small (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .bubble_i(bubble),
      .m_stat_i(m_stat), .m_icode_i(m_icode), .m_valE_i(m_valE), .m_valM_i(m_valM),
      .m_dstE_i(m_dstE), .m_dstM_i(m_dstM), .rd_addr_i(rd_addr), .rd_data_o(s_rd_data),
      .W_stat_o(s_w_stat), .W_icode_o(s_w_icode), .W_valE_o(s_w_valE), .W_valM_o(s_w_valM),
      .W_dstE_o(s_w_dstE), .W_dstM_o(s_w_dstM), .cpu_stat_o(s_cpu_stat), .halted_o(s_halted),
      .retired_cnt_o(s_cnt), .dbg_state_o(s_dbg_state)
   );

   // ---------------- scoreboard ----------------
   localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_CNT = 2, SEL_CSTAT = 3, SEL_HALT = 4;
   localparam int SEL_WSTAT = 5, SEL_WDSTE = 6, SEL_SCNT = 7, SEL_SWSTAT = 8, SEL_STATE = 9;

   logic [63:0] exp_q[$];
   int          sel_q[$];
   string       name_q[$];
   int          total = 0;
   int          bad   = 0;

   function automatic logic [63:0] observe(input int sel);
      case (sel)
         SEL_RD0:    return rd_data[63:0];
         SEL_RD1:    return rd_data[127:64];
         SEL_CNT:    return {32'd0, cnt};
         SEL_CSTAT:  return {61'd0, cpu_stat};
         SEL_HALT:   return {63'd0, halted};
         SEL_WSTAT:  return {61'd0, w_stat};
         SEL_WDSTE:  return {60'd0, w_dstE};
         SEL_SCNT:   return {60'd0, s_cnt};
         SEL_SWSTAT: return {61'd0, s_w_stat};
         SEL_STATE:  return {62'd0, dbg_state};
         default:    return '1;
      endcase
   endfunction

   // Monitor: drain all expectations queued for this cycle on the falling edge.
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         logic [63:0] e, a;
         int          s;
         string       n;
         e = exp_q.pop_front();
         s = sel_q.pop_front();
         n = name_q.pop_front();
         a = observe(s);
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic expect_val(input int sel, input logic [63:0] val, input string name);
      exp_q.push_back(val);
      sel_q.push_back(sel);
      name_q.push_back(name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input logic [2:0] st, input logic [3:0] ic,
                          input logic [63:0] ve, input logic [63:0] vm,
                          input logic [3:0] de, input logic [3:0] dm);
      m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm;
   endtask

   task automatic idle();
      drive_m(SBUB, INOP, 64'd0, 64'd0, RNONE, RNONE);
   endtask

   task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
      rd_addr = {a1, a0};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      stall = 1'b0; bubble = 1'b0;
      idle();
      set_rd(4'd3, 4'd4);
      do_reset();

      // reset state
      expect_val(SEL_CNT,   64'd0, "rst_cnt");
      expect_val(SEL_CSTAT, 64'(SAOK), "rst_cpu_stat");
      expect_val(SEL_HALT,  64'd0, "rst_halted");
      expect_val(SEL_WSTAT, 64'(SBUB), "rst_w_stat");
      expect_val(SEL_WDSTE, 64'(RNONE), "rst_w_dste");
      expect_val(SEL_RD0,   64'd0, "rst_r3");

      // 1: simple E write, bypass then array read
      drive_m(SAOK, 4'h6, 64'h11, 64'd0, 4'd3, RNONE);
      tick();
      idle();
      set_rd(4'd3, RNONE);
      expect_val(SEL_RD0, 64'h11, "t1_bypass_r3");
      expect_val(SEL_RD1, 64'd0,  "t1_rnone_read");
      expect_val(SEL_CNT, 64'd0,  "t1_cnt_before");
      tick();
      expect_val(SEL_RD0, 64'h11, "t1_array_r3");
      expect_val(SEL_CNT, 64'd1,  "t1_cnt");

      // 2: dstE==dstM, valM wins on both bypass and array
      drive_m(SAOK, 4'hB, 64'h20, 64'h30, 4'd4, 4'd4);
      tick();
      idle();
      set_rd(4'd3, 4'd4);
      expect_val(SEL_RD1, 64'h30, "t2_bypass_r4");
      tick();
      expect_val(SEL_RD1, 64'h30, "t2_array_r4");
      expect_val(SEL_RD0, 64'h11, "t2_r3_kept");
      expect_val(SEL_CNT, 64'd2,  "t2_cnt");

      // 3: stalled instruction retires exactly once
      drive_m(SAOK, 4'h6, 64'h55, 64'd0, 4'd5, RNONE);
      tick();
      idle();
      stall = 1'b1;
      tick(); tick(); tick();
      set_rd(4'd5, 4'd4);
      expect_val(SEL_CNT,   64'd3, "t3_cnt_stalled");
      expect_val(SEL_RD0,   64'h55, "t3_r5");
      expect_val(SEL_WDSTE, 64'd5, "t3_w_held");
      stall = 1'b0;
      tick();
      expect_val(SEL_CNT,   64'd3, "t3_cnt_after");

      // stall and bubble together: bubble wins, nothing retires
      drive_m(SAOK, 4'h6, 64'h66, 64'd0, 4'd6, RNONE);
      stall = 1'b1; bubble = 1'b1;
      tick();
      stall = 1'b0; bubble = 1'b0;
      idle();
      set_rd(4'd6, 4'd5);
      expect_val(SEL_WSTAT,  64'(SBUB), "sb_w_stat");
      expect_val(SEL_WDSTE,  64'(RNONE), "sb_w_dste");
      expect_val(SEL_SWSTAT, 64'(SBUB), "sb_small_w_stat");
      tick();
      expect_val(SEL_RD0, 64'd0, "sb_r6_unwritten");
      expect_val(SEL_CNT, 64'd3, "sb_cnt");

      // 4: halt retires, then later loads are inert
      drive_m(SHLT, IHALT, 64'd0, 64'd0, RNONE, RNONE);
      tick();
      idle();
      expect_val(SEL_HALT, 64'd0, "t4_not_yet_halted");
      tick();
      expect_val(SEL_HALT,  64'd1, "t4_halted");
      expect_val(SEL_CSTAT, 64'(SHLT), "t4_cpu_stat");
      expect_val(SEL_CNT,   64'd4, "t4_cnt");
      expect_val(SEL_STATE, 64'(ST_HALT), "t4_state");
      drive_m(SAOK, 4'h6, 64'h99, 64'd0, 4'd1, RNONE);
      tick();
      idle();
      set_rd(4'd1, 4'd3);
      expect_val(SEL_RD0, 64'd0, "t4_no_bypass_r1");
      tick();
      tick();
      expect_val(SEL_RD0, 64'd0, "t4_r1_unchanged");
      expect_val(SEL_CNT, 64'd4, "t4_cnt_frozen");

      // 5: reset clears everything; SADR fault then unknown-code fault
      do_reset();
      set_rd(4'd3, 4'd4);
      expect_val(SEL_CSTAT, 64'(SAOK), "t5_rst_cpu_stat");
      expect_val(SEL_HALT,  64'd0, "t5_rst_halted");
      expect_val(SEL_CNT,   64'd0, "t5_rst_cnt");
      expect_val(SEL_RD0,   64'd0, "t5_rst_r3");
      expect_val(SEL_RD1,   64'd0, "t5_rst_r4");
      drive_m(SADR, 4'h5, 64'h7, 64'd0, 4'd2, RNONE);
      tick();
      idle();
      set_rd(4'd2, 4'd3);
      tick();
      expect_val(SEL_HALT,  64'd1, "t5_err_halted");
      expect_val(SEL_CSTAT, 64'(SADR), "t5_cpu_stat_sadr");
      expect_val(SEL_RD0,   64'd0, "t5_r2_unwritten");
      expect_val(SEL_CNT,   64'd0, "t5_err_cnt");
      expect_val(SEL_STATE, 64'(ST_ERR), "t5_state");
      do_reset();
      drive_m(3'd6, 4'h6, 64'd0, 64'd0, RNONE, RNONE);
      tick();
      idle();
      tick();
      expect_val(SEL_CSTAT, 64'(SINS), "t5_unknown_sins");

      // 6: 17 back-to-back commits; 4-bit counter saturates at 15
      do_reset();
      for (int i = 1; i <= 17; i++) begin
         drive_m(SAOK, 4'h6, 64'(i), 64'd0, 4'd7, RNONE);
         tick();
      end
      idle();
      tick();
      set_rd(4'd7, RNONE);
      expect_val(SEL_CNT,  64'd17, "t6_cnt_wide");
      expect_val(SEL_SCNT, 64'd15, "t6_cnt_saturated");
      expect_val(SEL_RD0,  64'd17, "t6_r7_last");

      // let the monitor drain, bounded
      for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
      if (exp_q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
